pifo_root_node: RTL and testbench
=================================

# pifo_root_node

- Register-based root level of the BMW PIFO tree, directly upstream of the SRAM-backed RPU pair.
- Holds four {value, sub_tree_size} slots in flops and accepts push/pop commands from the scheduler over a valid/ready handshake.
- Returns the minimum element on pop and forwards displaced pushes or refill pops to the child level through the pair's i_push/i_pop interface.

## Interface
Parameters:
- PTW, 16, payload width
- MTW, 0, metadata width; element word W = MTW+PTW
- CTW, 10, sub-tree counter width
- ADW, 20, child address width
- BRANCH_CAP, 20, max elements below one slot (two 4-ary levels: 4+16)
- CMD_GAP, 2, minimum cycles between successive child commands
- POP_LAT, 1, cycles from o_pop to valid i_pop_data

Ports:
- i_clk  in  1  clock; one clock domain
- i_arst_n  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_push  in  1  1=push, 0=pop
- i_cmd_data  in  W  push element; ignored on pop
- o_pop_valid  out  1  one-cycle pulse, o_pop_data valid
- o_pop_data  out  W  popped element
- o_overflow  out  1  one-cycle pulse, push dropped (full)
- o_underflow  out  1  one-cycle pulse, pop on empty
- o_push  out  1  push to child
- o_push_data  out  W  element pushed to child
- o_pop  out  1  pop to child
- i_pop_data  in  W  child's popped element
- o_child_addr  out  ADW  branch index 0..3, zero-extended; valid with o_push/o_pop

## Operation
- Ordering: smaller unsigned W-bit word = higher priority; ties resolve to lowest slot index.
- Push into a tree with an empty slot: fill the lowest-index invalid slot; no child command.
- Push with all slots valid: the target is the slot with the smallest sub_tree_size, lowest index on ties.
  - If the target's size == BRANCH_CAP for all slots: drop and pulse o_overflow.
  - Otherwise, if new < slot value, swap and push the old value down; else push the new value down.
  - Increment the target size; o_child_addr = target index.
- Pop: select the argmin over valid slots and drive o_pop_data with it.
  - If the selected slot's size == 0: invalidate it.
  - Otherwise: decrement its size, issue o_pop with o_child_addr = index, and overwrite the slot value with i_pop_data at refill.
- Pop with no valid slot: pulse o_underflow; no o_pop_valid and no child command.
- FSM states:
  - IDLE: ready = 1.
  - GAP: counts the CMD_GAP spacing.
  - REFILL: waits for i_pop_data.
- Transitions:
  - IDLE→GAP on a push that goes down.
  - IDLE→REFILL on a pop that goes down.
  - GAP→IDLE and REFILL→IDLE when the counter expires.
  - Commands handled without a child command stay in IDLE.
- Size counters never wrap; saturation is prevented by the overflow check.

## Timing
- Command accepted at edge t.
- o_pop_valid/o_pop_data, o_push/o_pop/o_push_data/o_child_addr are registered and asserted in cycle t+1 for exactly one cycle.
- Same for o_overflow/o_underflow.
- Push-down: o_cmd_ready low cycles t+1..t+CMD_GAP-1 (with CMD_GAP=2, low at t+1 only).
- Pop-down: i_pop_data sampled at end of cycle t+1+POP_LAT and written to the slot.
  - o_cmd_ready low t+1..t+max(CMD_GAP-1, POP_LAT+1).
  - A subsequent pop therefore sees the refilled value.
- Back-to-back local-only commands: one per cycle.
- Reset values: o_cmd_ready=1 (state IDLE); all other outputs 0; all slots invalid, sizes 0, counter 0.
- Reset asserted mid-REFILL or mid-GAP: return immediately to IDLE with empty slots; later i_pop_data is ignored.
- i_cmd_data and i_cmd_push are sampled only on valid&ready.

## Structure
- Package pifo_pkg holds:
  - the slot struct {valid, value[W], size[CTW]};
  - the FSM enum {IDLE, GAP, REFILL};
  - the width helper function W.
- Sub-module pifo_argmin4: combinational argmin over four (valid, key) pairs returning {found, index}.
  - Instanced twice: once on values for pop, once on sizes for push target.

## Test plan
- Reset, then push 7,3,9,5 → no o_push; pops return 3,5,7,9 at t+1 each; 5th pop → o_underflow=1, o_pop_valid=0.
- Fill 4 slots with 10,20,30,40, then push 5 → o_push=1, o_push_data=10, o_child_addr=0, slot0 value 5, size0=1, ready low one cycle.
- Then push 50 → o_push_data=50, o_child_addr=1; sizes {1,1,0,0}.
- From the previous state, pop with the child returning 10 at t+2 → o_pop_data=5, o_pop=1, o_child_addr=0; next pop returns 10.
- Drive all sizes to BRANCH_CAP=20 (84 elements), push 1 → o_overflow pulse, state unchanged; pop still returns the minimum.
- Assert i_arst_n low during REFILL → o_cmd_ready=1, all outputs 0, next pop → o_underflow.

Source files
------------

// File: rtl/pifo_pkg.sv
// Shared types for the PIFO root node.
// Contents:
//   elem_w    element word width helper (metadata + payload)
//   state_t   root-node sequencer states
//   slot_t    {valid, value, size} slot at the default geometry
//             (MTW=0, PTW=16, CTW=10). The root node declares the same
//             layout locally at its parameterised widths.
package pifo_pkg;

    function automatic int elem_w(input int mtw, input int ptw);
        return mtw + ptw;
    endfunction

    localparam int DEF_PTW = 16;
    localparam int DEF_MTW = 0;
    localparam int DEF_CTW = 10;
    localparam int DEF_W   = elem_w(DEF_MTW, DEF_PTW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        REFILL = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [DEF_W-1:0]   value;
        logic [DEF_CTW-1:0] size;
    } slot_t;

endpackage

// File: rtl/pifo_argmin4.sv
// Combinational argmin over four (valid, key) pairs.
// Ports:
//   valid  in   4      per-entry valid
//   key    in   4xKW   per-entry key, unsigned
//   found  out  1      at least one entry valid
//   index  out  2      smallest valid key; ties go to the lowest index
module pifo_argmin4 #(
    parameter int KW = 16
) (
    input  logic [3:0]    valid,
    input  logic [KW-1:0] key [4],
    output logic          found,
    output logic [1:0]    index
);

    logic [KW-1:0] best;

    always_comb begin
        found = 1'b0;
        index = 2'd0;
        best  = '0;
        for (int i = 0; i < 4; i++) begin
            // Strict less-than keeps the earlier index on equal keys.
            if (valid[i] && (!found || key[i] < best)) begin
                found = 1'b1;
                index = 2'(i);
                best  = key[i];
            end
        end
    end

endmodule

// File: rtl/pifo_root_node.sv
// Register-based root level of the BMW PIFO tree. Four {value, size}
// slots live in flops. Pops return the minimum. Pushes into a full node,
// and pops from a slot that has a sub-tree, are forwarded to the child
// level through the RPU pair's push/pop interface.
//
// Ports:
//   i_clk, i_arst_n         clock, async active-low reset
//   i_cmd_valid/o_cmd_ready command handshake
//   i_cmd_push, i_cmd_data  1=push / 0=pop; element word for push
//   o_pop_valid, o_pop_data popped element (1-cycle pulse)
//   o_overflow/o_underflow  dropped push / pop on empty (1-cycle pulse)
//   o_push, o_push_data     push to child
//   o_pop, i_pop_data       pop to child; child's returned element
//   o_child_addr            branch index 0..3, zero-extended
//
// state  | meaning
// IDLE   | ready for a command
// GAP    | spacing child commands after a push-down
// REFILL | waiting for the child's element to refill a popped slot
module pifo_root_node
    import pifo_pkg::*;
#(
    parameter  int PTW        = 16,
    parameter  int MTW        = 0,
    parameter  int CTW        = 10,
    parameter  int ADW        = 20,
    parameter  int BRANCH_CAP = 20,
    parameter  int CMD_GAP    = 2,
    parameter  int POP_LAT    = 1,
    localparam int W          = elem_w(MTW, PTW)
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    input  logic           i_cmd_valid,
    output logic           o_cmd_ready,
    input  logic           i_cmd_push,
    input  logic [W-1:0]   i_cmd_data,
    output logic           o_pop_valid,
    output logic [W-1:0]   o_pop_data,
    output logic           o_overflow,
    output logic           o_underflow,
    output logic           o_push,
    output logic [W-1:0]   o_push_data,
    output logic           o_pop,
    input  logic [W-1:0]   i_pop_data,
    output logic [ADW-1:0] o_child_addr
);

    localparam int CNT_W      = 8;
    localparam int GAP_LOAD   = (CMD_GAP > 1) ? CMD_GAP - 2 : 0;
    localparam int REFILL_LEN = (CMD_GAP - 1 > POP_LAT + 1) ? CMD_GAP - 1 : POP_LAT + 1;
    // Counter value during the cycle whose closing edge samples i_pop_data.
    localparam int REFILL_TAKE = REFILL_LEN - POP_LAT - 1;

    logic [3:0]     slot_valid;
    logic [W-1:0]   slot_value [4];
    logic [CTW-1:0] slot_size  [4];

    state_t         state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]     refill_idx;
    logic           refill_take;

    logic           val_found, size_found;
    logic [1:0]     val_idx, size_idx;
    logic [1:0]     free_idx;
    logic           all_full;

    logic           accept;
    logic           push_local, push_down, push_ovf;
    logic           pop_local, pop_down, pop_empty;
    logic           push_swap;

    pifo_argmin4 #(.KW(W)) u_min_value (
        .valid (slot_valid),
        .key   (slot_value),
        .found (val_found),
        .index (val_idx)
    );

    // Push target: least-populated sub-tree among all slots.
    pifo_argmin4 #(.KW(CTW)) u_min_size (
        .valid (slot_valid),
        .key   (slot_size),
        .found (size_found),
        .index (size_idx)
    );

    always_comb begin
        free_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!slot_valid[i]) free_idx = 2'(i);
        end
    end

    assign all_full  = &slot_valid;
    assign accept    = i_cmd_valid & o_cmd_ready;
    assign push_swap = i_cmd_data < slot_value[size_idx];

    // Overflow only when the least-populated target is already at the cap,
    // i.e. every branch is at the cap. This is also what keeps sizes from wrapping.
    always_comb begin
        push_local = accept &  i_cmd_push & ~all_full;
        push_ovf   = accept &  i_cmd_push &  all_full & size_found
                   & (slot_size[size_idx] == CTW'(BRANCH_CAP));
        push_down  = accept &  i_cmd_push &  all_full & size_found
                   & (slot_size[size_idx] != CTW'(BRANCH_CAP));
        pop_empty  = accept & ~i_cmd_push & ~val_found;
        pop_local  = accept & ~i_cmd_push &  val_found & (slot_size[val_idx] == '0);
        pop_down   = accept & ~i_cmd_push &  val_found & (slot_size[val_idx] != '0);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (pop_down) begin
                    state_nxt = REFILL;
                    cnt_nxt   = CNT_W'(REFILL_LEN - 1);
                end else if (push_down && CMD_GAP > 1) begin
                    state_nxt = GAP;
                    cnt_nxt   = CNT_W'(GAP_LOAD);
                end
            end
            GAP, REFILL: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        o_cmd_ready = (state == IDLE);
        refill_take = (state == REFILL) && (cnt == CNT_W'(REFILL_TAKE));
    end

    // Slot storage
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            slot_valid <= '0;
            refill_idx <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_value[i] <= '0;
                slot_size[i]  <= '0;
            end
        end else begin
            if (push_local) begin
                slot_valid[free_idx] <= 1'b1;
                slot_value[free_idx] <= i_cmd_data;
                slot_size[free_idx]  <= '0;
            end
            if (push_down) begin
                if (push_swap) slot_value[size_idx] <= i_cmd_data;
                slot_size[size_idx] <= slot_size[size_idx] + CTW'(1);
            end
            if (pop_local) begin
                slot_valid[val_idx] <= 1'b0;
            end
            if (pop_down) begin
                slot_size[val_idx] <= slot_size[val_idx] - CTW'(1);
                refill_idx         <= val_idx;
            end
            // The popped slot keeps its valid bit; its value is stale
            // until the child's element lands here.
            if (refill_take) begin
                slot_value[refill_idx] <= i_pop_data;
            end
        end
    end

    // Registered command results; every field returns to zero after its pulse.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_pop_valid  <= 1'b0;
            o_pop_data   <= '0;
            o_overflow   <= 1'b0;
            o_underflow  <= 1'b0;
            o_push       <= 1'b0;
            o_push_data  <= '0;
            o_pop        <= 1'b0;
            o_child_addr <= '0;
        end else begin
            o_pop_valid  <= 1'b0;
            o_pop_data   <= '0;
            o_overflow   <= push_ovf;
            o_underflow  <= pop_empty;
            o_push       <= 1'b0;
            o_push_data  <= '0;
            o_pop        <= 1'b0;
            o_child_addr <= '0;
            if (pop_local || pop_down) begin
                o_pop_valid <= 1'b1;
                o_pop_data  <= slot_value[val_idx];
            end
            if (pop_down) begin
                o_pop        <= 1'b1;
                o_child_addr <= ADW'(val_idx);
            end
            if (push_down) begin
                o_push       <= 1'b1;
                o_push_data  <= push_swap ? slot_value[size_idx] : i_cmd_data;
                o_child_addr <= ADW'(size_idx);
            end
        end
    end

endmodule

// File: tb/tb_pifo_root_node.sv
module tb_pifo_root_node;

    localparam int W   = 16;
    localparam int ADW = 20;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_push = 1'b0;
    logic [W-1:0]   cmd_data = '0;
    logic           pop_valid;
    logic [W-1:0]   pop_data;
    logic           overflow;
    logic           underflow;
    logic           push_o;
    logic [W-1:0]   push_data;
    logic           pop_o;
    logic [W-1:0]   child_pop_data = 16'hFFFF;
    logic [ADW-1:0] child_addr;

    int checks = 0;
    int errors = 0;

    pifo_root_node dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_push   (cmd_push),
        .i_cmd_data   (cmd_data),
        .o_pop_valid  (pop_valid),
        .o_pop_data   (pop_data),
        .o_overflow   (overflow),
        .o_underflow  (underflow),
        .o_push       (push_o),
        .o_push_data  (push_data),
        .o_pop        (pop_o),
        .i_pop_data   (child_pop_data),
        .o_child_addr (child_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one command; returns #1 after the accepting edge, i.e. in cycle t+1.
    task automatic send(input logic push, input logic [W-1:0] data);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout got=%b want=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_push  = push;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_push  = 1'b0;
        cmd_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want=1", cmd_ready);
        end
        checks++;
        if ({pop_valid, pop_data, overflow, underflow, push_o, push_data, pop_o, child_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pv=%b pd=%h ov=%b un=%b pu=%b pud=%h po=%b ad=%h want all 0",
                     pop_valid, pop_data, overflow, underflow, push_o, push_data, pop_o, child_addr);
        end
        arst_n = 1'b1;
    endtask

    task automatic test_local();
        logic [W-1:0] pushes [4];
        logic [W-1:0] exp    [4];
        pushes = '{16'd7, 16'd3, 16'd9, 16'd5};
        exp    = '{16'd3, 16'd5, 16'd7, 16'd9};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, pushes[i]);
            checks++;
            if (push_o !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL local_push%0d got push=%b ready=%b want push=0 ready=1", i, push_o, cmd_ready);
            end
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b0, '0);
            checks++;
            if (pop_valid !== 1'b1 || pop_data !== exp[i] || pop_o !== 1'b0) begin
                errors++;
                $display("FAIL local_pop%0d got valid=%b data=%0d child_pop=%b want valid=1 data=%0d child_pop=0",
                         i, pop_valid, pop_data, pop_o, exp[i]);
            end
        end
        send(1'b0, '0);
        checks++;
        if (underflow !== 1'b1 || pop_valid !== 1'b0 || pop_o !== 1'b0) begin
            errors++;
            $display("FAIL underflow got un=%b pv=%b po=%b want un=1 pv=0 po=0", underflow, pop_valid, pop_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pulse got=%b want=0", underflow);
        end
    endtask

    task automatic test_push_down();
        do_reset();
        send(1'b1, 16'd10);
        send(1'b1, 16'd20);
        send(1'b1, 16'd30);
        send(1'b1, 16'd40);
        send(1'b1, 16'd5);
        checks++;
        if (push_o !== 1'b1 || push_data !== 16'd10 || child_addr !== 20'd0) begin
            errors++;
            $display("FAIL push_swap got push=%b data=%0d addr=%0d want push=1 data=10 addr=0",
                     push_o, push_data, child_addr);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL push_gap_ready got=%b want=0", cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || push_o !== 1'b0) begin
            errors++;
            $display("FAIL push_gap_end got ready=%b push=%b want ready=1 push=0", cmd_ready, push_o);
        end
        send(1'b1, 16'd50);
        checks++;
        if (push_o !== 1'b1 || push_data !== 16'd50 || child_addr !== 20'd1) begin
            errors++;
            $display("FAIL push_new got push=%b data=%0d addr=%0d want push=1 data=50 addr=1",
                     push_o, push_data, child_addr);
        end
    endtask

    // Continues from test_push_down: slots {5,20,30,40}, sizes {1,1,0,0}.
    task automatic test_pop_refill();
        send(1'b0, '0);
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 16'd5 || pop_o !== 1'b1 || child_addr !== 20'd0) begin
            errors++;
            $display("FAIL refill_pop got pv=%b data=%0d po=%b addr=%0d want pv=1 data=5 po=1 addr=0",
                     pop_valid, pop_data, pop_o, child_addr);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL refill_ready_t1 got=%b want=0", cmd_ready);
        end
        @(posedge clk);
        #1;
        child_pop_data = 16'd10;
        checks++;
        if (cmd_ready !== 1'b0 || pop_o !== 1'b0) begin
            errors++;
            $display("FAIL refill_ready_t2 got ready=%b po=%b want ready=0 po=0", cmd_ready, pop_o);
        end
        @(posedge clk);
        #1;
        child_pop_data = 16'hFFFF;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL refill_ready_t3 got=%b want=1", cmd_ready);
        end
        send(1'b0, '0);
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 16'd10 || pop_o !== 1'b0) begin
            errors++;
            $display("FAIL refill_next got pv=%b data=%0d po=%b want pv=1 data=10 po=0",
                     pop_valid, pop_data, pop_o);
        end
        send(1'b0, '0);
        checks++;
        if (pop_data !== 16'd20 || pop_o !== 1'b1 || child_addr !== 20'd1) begin
            errors++;
            $display("FAIL refill_slot1 got data=%0d po=%b addr=%0d want data=20 po=1 addr=1",
                     pop_data, pop_o, child_addr);
        end
        @(posedge clk);
        #1;
        child_pop_data = 16'd60;
        @(posedge clk);
        #1;
        child_pop_data = 16'hFFFF;
    endtask

    task automatic test_overflow();
        int bad = 0;
        do_reset();
        send(1'b1, 16'd100);
        send(1'b1, 16'd200);
        send(1'b1, 16'd300);
        send(1'b1, 16'd400);
        for (int i = 0; i < 80; i++) begin
            send(1'b1, 16'd500);
            if (push_o !== 1'b1 || push_data !== 16'd500 || child_addr !== ADW'(i % 4)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fill_pushes got %0d bad push-downs want 0", bad);
        end
        send(1'b1, 16'd1);
        checks++;
        if (overflow !== 1'b1 || push_o !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL overflow got ov=%b push=%b ready=%b want ov=1 push=0 ready=1",
                     overflow, push_o, cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pulse got=%b want=0", overflow);
        end
        send(1'b0, '0);
        checks++;
        if (pop_data !== 16'd100 || pop_o !== 1'b1 || child_addr !== 20'd0) begin
            errors++;
            $display("FAIL overflow_pop got data=%0d po=%b addr=%0d want data=100 po=1 addr=0",
                     pop_data, pop_o, child_addr);
        end
        @(posedge clk);
        #1;
        child_pop_data = 16'd150;
        @(posedge clk);
        #1;
        child_pop_data = 16'hFFFF;
        send(1'b0, '0);
        checks++;
        if (pop_data !== 16'd150 || pop_o !== 1'b1 || child_addr !== 20'd0) begin
            errors++;
            $display("FAIL overflow_pop2 got data=%0d po=%b addr=%0d want data=150 po=1 addr=0",
                     pop_data, pop_o, child_addr);
        end
        @(posedge clk);
        #1;
        child_pop_data = 16'd600;
        @(posedge clk);
        #1;
        child_pop_data = 16'hFFFF;
    endtask

    // Continues from test_overflow: slot0 has a non-empty sub-tree.
    task automatic test_reset_refill();
        send(1'b0, '0);
        checks++;
        if (pop_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_refill_enter got po=%b want 1", pop_o);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_refill_ready got=%b want=1", cmd_ready);
        end
        checks++;
        if ({pop_valid, pop_data, overflow, underflow, push_o, push_data, pop_o, child_addr} !== '0) begin
            errors++;
            $display("FAIL rst_refill_outputs got pv=%b pd=%h ov=%b un=%b pu=%b pud=%h po=%b ad=%h want all 0",
                     pop_valid, pop_data, overflow, underflow, push_o, push_data, pop_o, child_addr);
        end
        child_pop_data = 16'd3;
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        child_pop_data = 16'hFFFF;
        send(1'b0, '0);
        checks++;
        if (underflow !== 1'b1 || pop_valid !== 1'b0 || pop_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_refill_pop got un=%b pv=%b po=%b want un=1 pv=0 po=0",
                     underflow, pop_valid, pop_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pushes [4];
        logic [W-1:0] exp    [4];
        pushes = '{16'd8, 16'd2, 16'd6, 16'd4};
        exp    = '{16'd2, 16'd4, 16'd6, 16'd8};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_push  = 1'b1;
            cmd_data  = pushes[i];
            @(posedge clk);
            #1;
            checks++;
            if (cmd_ready !== 1'b1 || push_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_push%0d got ready=%b push=%b want ready=1 push=0", i, cmd_ready, push_o);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_push  = 1'b0;
            cmd_data  = '0;
            @(posedge clk);
            #1;
            checks++;
            if (pop_valid !== 1'b1 || pop_data !== exp[i] || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_pop%0d got pv=%b data=%0d ready=%b want pv=1 data=%0d ready=1",
                         i, pop_valid, pop_data, cmd_ready, exp[i]);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_local();
        test_push_down();
        test_pop_refill();
        test_overflow();
        test_reset_refill();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
